pov_frame_sequencer: RTL and testbench

//  Parametrised successor to the single-strip frame timer/address mapper in the POV top level.

---
 rtl/pov_pkg.sv | 25 ++
 rtl/pov_frame_timer.sv | 131 +++++++++++++
 rtl/pov_frame_sequencer.sv | 125 ++++++++++++
 tb/tb_pov_frame_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pov_pkg.sv
// Shared play-mode encodings, FSM state type and sizing helpers for the POV frame sequencer.
package pov_pkg;

   localparam logic [1:0] MODE_LOOP     = 2'b00;
   localparam logic [1:0] MODE_PINGPONG = 2'b01;
   localparam logic [1:0] MODE_ONESHOT  = 2'b10;
   localparam logic [1:0] MODE_PAUSE    = 2'b11;

   typedef enum logic [1:0] {
      ST_UP   = 2'd0,
      ST_DOWN = 2'd1,
      ST_DONE = 2'd2
   } play_state_t;

   function automatic int frame_size(input int led_count, input int tex_width);
      return led_count * tex_width;
   endfunction

   function automatic int addr_w(input int led_count, input int tex_width, input int num_frames);
      int w;
      w = $clog2(frame_size(led_count, tex_width) * num_frames);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pov_frame_timer.sv
// Animation timer and play-mode FSM: produces frame_tick, the frame index and its ROM base offset.
// The FSM state is exported so the parent (and checkers) can observe direction and completion.
module pov_frame_timer
   import pov_pkg::*;
#(
   parameter int LED_COUNT  = 52,
   parameter int TEX_WIDTH  = 64,
   parameter int NUM_FRAMES = 237,
   parameter int ADDR_W     = addr_w(LED_COUNT, TEX_WIDTH, NUM_FRAMES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic [31:0]       cycles_per_frame,
   input  logic              start,
   output logic              frame_tick,
   output logic [7:0]        frame_idx,
   output logic [ADDR_W-1:0] frame_base,
   output play_state_t       state
);

   localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(frame_size(LED_COUNT, TEX_WIDTH));
   localparam logic [7:0]        LAST     = 8'(NUM_FRAMES - 1);

   logic [31:0]       timer_q, timer_d;
   logic              tick_q, tick_d;
   logic [7:0]        frame_q, frame_d;
   logic [ADDR_W-1:0] base_q, base_d;
   play_state_t       state_q, state_d;
   logic [1:0]        mode_q;
   logic              run;

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
         tick_q  <= 1'b0;
         frame_q <= '0;
         base_q  <= '0;
         state_q <= ST_UP;
         mode_q  <= MODE_LOOP;
      end else begin
         timer_q <= timer_d;
         tick_q  <= tick_d;
         frame_q <= frame_d;
         base_q  <= base_d;
         state_q <= state_d;
         mode_q  <= mode;
      end
   end

   always_comb begin
      timer_d = timer_q;
      tick_d  = 1'b0;
      frame_d = frame_q;
      base_d  = base_q;
      state_d = state_q;
      run     = (mode != MODE_PAUSE) && (cycles_per_frame != 32'd0);

      // >= so that lowering cycles_per_frame mid-count expires immediately
      if (run) begin
         if (timer_q >= cycles_per_frame - 32'd1) begin
            timer_d = '0;
            tick_d  = 1'b1;
         end else begin
            timer_d = timer_q + 32'd1;
         end
      end

      if ((mode != mode_q) && (state_q == ST_DONE))
         state_d = ST_UP;

      // frame_base moves by +/-FRAME_SZ alongside frame_idx, so no multiplier is needed
      if (tick_q) begin
         case (mode)
            MODE_LOOP: begin
               if (frame_q == LAST) begin
                  frame_d = '0;
                  base_d  = '0;
               end else begin
                  frame_d = frame_q + 8'd1;
                  base_d  = base_q + FRAME_SZ;
               end
            end
            MODE_PINGPONG: begin
               if (state_d == ST_DOWN) begin
                  if (frame_q != 8'd0) begin
                     frame_d = frame_q - 8'd1;
                     base_d  = base_q - FRAME_SZ;
                  end else begin
                     frame_d = frame_q + 8'd1;
                     base_d  = base_q + FRAME_SZ;
                     state_d = ST_UP;
                  end
               end else if (frame_q != LAST) begin
                  frame_d = frame_q + 8'd1;
                  base_d  = base_q + FRAME_SZ;
               end else if (LAST != 8'd0) begin
                  frame_d = frame_q - 8'd1;
                  base_d  = base_q - FRAME_SZ;
                  state_d = ST_DOWN;
               end
            end
            MODE_ONESHOT: begin
               if (state_d != ST_DONE) begin
                  if (frame_q != LAST) begin
                     frame_d = frame_q + 8'd1;
                     base_d  = base_q + FRAME_SZ;
                  end
                  if ((frame_q == LAST) || (frame_q + 8'd1 == LAST))
                     state_d = ST_DONE;
               end
            end
            default: ;
         endcase
      end

      if (start) begin
         timer_d = '0;
         tick_d  = 1'b0;
         frame_d = '0;
         base_d  = '0;
         state_d = ST_UP;
      end
   end

   assign frame_tick = tick_q;
   assign frame_idx  = frame_q;
   assign frame_base = base_q;
   assign state      = state_q;

endmodule

// File: rtl/pov_frame_sequencer.sv
// POV frame sequencer: animation timing plus a 2-stage per-strip texture ROM address pipeline.
// Optional macro POV_SYNC_SWAP_EN defers frame changes to the next theta wrap (tear-free).
module pov_frame_sequencer
   import pov_pkg::*;
#(
   parameter int LED_COUNT  = 52,
   parameter int TEX_WIDTH  = 64,
   parameter int THETA_BITS = 6,
   parameter int PX_BITS    = 6,
   parameter int NUM_FRAMES = 237,
   parameter int NUM_CH     = 2,
   parameter int ADDR_W     = addr_w(LED_COUNT, TEX_WIDTH, NUM_FRAMES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 mode,
   input  logic [31:0]                cycles_per_frame,
   input  logic                       start,
   input  logic [THETA_BITS-1:0]      theta,
   input  logic [NUM_CH*PX_BITS-1:0]  px_num,
   output logic [NUM_CH*ADDR_W-1:0]   rom_addr,
   output logic [7:0]                 frame_idx,
   output logic                       frame_tick,
   output logic                       done
);

   logic              tm_tick;
   logic [7:0]        tm_frame;
   logic [ADDR_W-1:0] tm_base;
   play_state_t       tm_state;
   logic [7:0]        disp_frame;
   logic [ADDR_W-1:0] disp_base;
   logic [ADDR_W-1:0] base_s1;

   pov_frame_timer #(
      .LED_COUNT  (LED_COUNT),
      .TEX_WIDTH  (TEX_WIDTH),
      .NUM_FRAMES (NUM_FRAMES),
      .ADDR_W     (ADDR_W)
   ) u_timer (
      .clk              (clk),
      .reset            (reset),
      .mode             (mode),
      .cycles_per_frame (cycles_per_frame),
      .start            (start),
      .frame_tick       (tm_tick),
      .frame_idx        (tm_frame),
      .frame_base       (tm_base),
      .state            (tm_state)
   );

`ifdef POV_SYNC_SWAP_EN
   logic [THETA_BITS-1:0] theta_q;
   logic                  pending_q;
   logic [7:0]            swap_frame_q;
   logic [ADDR_W-1:0]     swap_base_q;
   logic                  wrap;

   assign wrap = theta < theta_q;

   // The timer holds the "next" frame; the displayed copy only moves on a revolution boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         theta_q      <= '0;
         pending_q    <= 1'b0;
         swap_frame_q <= '0;
         swap_base_q  <= '0;
      end else begin
         theta_q <= theta;
         if (start) begin
            pending_q    <= 1'b0;
            swap_frame_q <= '0;
            swap_base_q  <= '0;
         end else begin
            if (wrap && pending_q) begin
               swap_frame_q <= tm_frame;
               swap_base_q  <= tm_base;
            end
            if (tm_tick)
               pending_q <= 1'b1;
            else if (wrap && pending_q)
               pending_q <= 1'b0;
         end
      end
   end

   assign disp_frame = swap_frame_q;
   assign disp_base  = swap_base_q;
`else
   assign disp_frame = tm_frame;
   assign disp_base  = tm_base;
`endif

   always_ff @(posedge clk) begin
      if (reset) base_s1 <= '0;
      else       base_s1 <= disp_base;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [THETA_BITS-1:0] COL_OFF = THETA_BITS'(c * TEX_WIDTH / NUM_CH);

      logic [THETA_BITS-1:0] col_q;
      logic [ADDR_W-1:0]     pxo_q;
      logic [ADDR_W-1:0]     sum_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            col_q <= '0;
            pxo_q <= '0;
            sum_q <= '0;
         end else begin
            col_q <= theta + COL_OFF;
            pxo_q <= ADDR_W'(px_num[c*PX_BITS +: PX_BITS]) << THETA_BITS;
            sum_q <= base_s1 + pxo_q + ADDR_W'(col_q);
         end
      end

      assign rom_addr[c*ADDR_W +: ADDR_W] = sum_q;
   end

   assign frame_idx  = disp_frame;
   assign frame_tick = tm_tick;
   assign done       = (tm_state == ST_DONE);

endmodule

// File: tb/tb_pov_frame_sequencer.sv
// Self-checking bench for pov_frame_sequencer: directed scenarios plus randomized play against
// a behavioural frame/address model checked every cycle.
module tb_pov_frame_sequencer;

   localparam int LED_COUNT  = 4;
   localparam int TEX_WIDTH  = 8;
   localparam int THETA_BITS = 3;
   localparam int PX_BITS    = 3;
   localparam int NUM_FRAMES = 3;
   localparam int NUM_CH     = 2;
   localparam int ADDR_W     = $clog2(TEX_WIDTH * LED_COUNT * NUM_FRAMES);
   localparam int FS         = LED_COUNT * TEX_WIDTH;
   localparam int AW         = NUM_CH * ADDR_W;

   // ---------------- clock / reset / DUT ----------------
   logic                      clk = 1'b0;
   logic                      reset;
   logic [1:0]                mode;
   logic [31:0]               cycles_per_frame;
   logic                      start;
   logic [THETA_BITS-1:0]     theta;
   logic [NUM_CH*PX_BITS-1:0] px_num;
   logic [AW-1:0]             rom_addr;
   logic [7:0]                frame_idx;
   logic                      frame_tick;
   logic                      done;

   always #5 clk = ~clk;

   pov_frame_sequencer #(
      .LED_COUNT  (LED_COUNT),
      .TEX_WIDTH  (TEX_WIDTH),
      .THETA_BITS (THETA_BITS),
      .PX_BITS    (PX_BITS),
      .NUM_FRAMES (NUM_FRAMES),
      .NUM_CH     (NUM_CH)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .mode             (mode),
      .cycles_per_frame (cycles_per_frame),
      .start            (start),
      .theta            (theta),
      .px_num           (px_num),
      .rom_addr         (rom_addr),
      .frame_idx        (frame_idx),
      .frame_tick       (frame_tick),
      .done             (done)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model / scoreboard ----------------
   int            m_timer, m_tick, m_frame, m_dir, m_done, m_mode_prev;
   int            m_disp, m_pending, m_theta_prev;
   logic [AW-1:0] m_exp;
   logic [AW-1:0] exp_q[$];
   bit            chk_en = 0;

   always @(posedge clk) begin
      int            prev_frame, old_pending, nt, px_c, col_c;
      bit            wrap;
      logic [AW-1:0] a;
      if (reset) begin
         m_timer = 0; m_tick = 0; m_frame = 0; m_dir = 0; m_done = 0; m_mode_prev = 0;
         m_disp = 0; m_pending = 0; m_theta_prev = 0;
         exp_q.delete();
         exp_q.push_back('0);
         m_exp  = '0;
         chk_en = 1;
      end else begin
         // address seen two cycles after theta/px/displayed frame
         a = '0;
         for (int c = 0; c < NUM_CH; c++) begin
            px_c  = int'(px_num[c*PX_BITS +: PX_BITS]);
            col_c = (int'(theta) + c * TEX_WIDTH / NUM_CH) % TEX_WIDTH;
            a[c*ADDR_W +: ADDR_W] = ADDR_W'((m_disp * FS + px_c * TEX_WIDTH + col_c) % (1 << ADDR_W));
         end
         exp_q.push_back(a);
         m_exp = exp_q.pop_front();

         nt          = 0;
         prev_frame  = m_frame;
         old_pending = m_pending;
         wrap        = int'(theta) < m_theta_prev;
         if (start) begin
            m_timer = 0; m_frame = 0; m_dir = 0; m_done = 0; m_pending = 0; m_disp = 0;
         end else begin
            if (mode != 2'b11 && cycles_per_frame != 0) begin
               if (m_timer >= int'(cycles_per_frame) - 1) begin
                  m_timer = 0;
                  nt      = 1;
               end else begin
                  m_timer++;
               end
            end
            if (int'(mode) != m_mode_prev) m_done = 0;
            if (m_tick != 0) begin
               case (mode)
                  2'b00: m_frame = (m_frame == NUM_FRAMES - 1) ? 0 : m_frame + 1;
                  2'b01: begin
                     if (m_dir == 0) begin
                        if (m_frame < NUM_FRAMES - 1) m_frame++;
                        else if (NUM_FRAMES > 1) begin m_frame--; m_dir = 1; end
                     end else begin
                        if (m_frame > 0) m_frame--;
                        else begin m_frame++; m_dir = 0; end
                     end
                  end
                  2'b10: begin
                     if (m_done == 0) begin
                        if (m_frame < NUM_FRAMES - 1) m_frame++;
                        if (m_frame == NUM_FRAMES - 1) begin m_done = 1; m_dir = 0; end
                     end
                  end
                  default: ;
               endcase
            end
`ifdef POV_SYNC_SWAP_EN
            if (wrap && old_pending != 0) m_disp = prev_frame;
            if (m_tick != 0) m_pending = 1;
            else if (wrap && old_pending != 0) m_pending = 0;
`else
            m_disp = m_frame;
`endif
         end
         m_tick       = nt;
         m_mode_prev  = int'(mode);
         m_theta_prev = int'(theta);
      end
      #1;
      if (chk_en) begin
         check("cmp_frame_tick", {31'd0, frame_tick}, m_tick);
         check("cmp_frame_idx", {24'd0, frame_idx}, m_disp);
         check("cmp_done", {31'd0, done}, m_done);
         check("cmp_rom_addr", 32'(rom_addr), 32'(m_exp));
      end
   end

   // ---------------- driver ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input logic [1:0] new_mode);
      start = 1'b1;
      mode  = new_mode;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      int pp_exp[6] = '{1, 2, 1, 0, 1, 2};
      int os_exp[4] = '{1, 2, 2, 2};
      int os_done[4] = '{0, 1, 1, 1};

      reset = 1'b1; mode = 2'b00; cycles_per_frame = 32'd4; start = 1'b0;
      theta = '0; px_num = '0;
      step(2);
      reset = 1'b0;
      check("reset_frame_idx", {24'd0, frame_idx}, 0);
      check("reset_tick", {31'd0, frame_tick}, 0);
      check("reset_done", {31'd0, done}, 0);
      check("reset_rom_addr", 32'(rom_addr), 0);

      // loop: tick every 4 cycles, frames 0,1,2,0
      step(4);
      check("loop_tick", {31'd0, frame_tick}, 1);
      check("loop_f0", {24'd0, frame_idx}, 0);
      step(1);
      check("loop_f1", {24'd0, frame_idx}, 1);
      check("loop_tick_clear", {31'd0, frame_tick}, 0);
      step(2);
      check("loop_base32_ch0", 32'(rom_addr[ADDR_W-1:0]), 32);
      check("loop_base32_ch1", 32'(rom_addr[2*ADDR_W-1:ADDR_W]), 36);
      step(2);
      check("loop_f2", {24'd0, frame_idx}, 2);
      step(4);
      check("loop_wrap_f0", {24'd0, frame_idx}, 0);

      // ping-pong
      pulse_start(2'b01);
      step(1);
      for (int k = 0; k < 6; k++) begin
         step(4);
         check("pp_frame", {24'd0, frame_idx}, pp_exp[k]);
         check("pp_done", {31'd0, done}, 0);
      end

      // one-shot, then restart
      pulse_start(2'b10);
      step(1);
      for (int k = 0; k < 4; k++) begin
         step(4);
         check("os_frame", {24'd0, frame_idx}, os_exp[k]);
         check("os_done", {31'd0, done}, os_done[k]);
      end
      pulse_start(2'b10);
      check("os_restart_frame", {24'd0, frame_idx}, 0);
      check("os_restart_done", {31'd0, done}, 0);

      // address at frame 1
      pulse_start(2'b00);
      step(5);
      check("addr_frame1", {24'd0, frame_idx}, 1);
      theta  = 3'd6;
      px_num = {3'd3, 3'd2};
      step(2);
      check("addr_ch0", 32'(rom_addr[ADDR_W-1:0]), 54);
      check("addr_ch1", 32'(rom_addr[2*ADDR_W-1:ADDR_W]), 58);
      theta = '0; px_num = '0;

      // start coinciding with a tick
      step(1);
      check("st_tick_seen", {31'd0, frame_tick}, 1);
      pulse_start(2'b00);
      check("st_wins_frame", {24'd0, frame_idx}, 0);
      step(3);
      check("st_timer0_no_tick", {31'd0, frame_tick}, 0);
      step(1);
      check("st_timer0_tick", {31'd0, frame_tick}, 1);

      // lowering cycles_per_frame mid-count
      cycles_per_frame = 32'd100;
      pulse_start(2'b00);
      step(50);
      check("cpf_no_tick", {31'd0, frame_tick}, 0);
      cycles_per_frame = 32'd4;
      step(1);
      check("cpf_drop_tick", {31'd0, frame_tick}, 1);
      step(1);
      check("cpf_drop_frame", {24'd0, frame_idx}, 1);

      // randomized play
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) cycles_per_frame = 32'($urandom_range(0, 6));
         if ($urandom_range(0, 9) < 7) theta = theta + 3'd1;
         else                          theta = 3'($urandom_range(0, 7));
         px_num = NUM_CH * PX_BITS'($urandom);
         step(1);
      end
      reset = 1'b0; start = 1'b0;
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
